// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z-sequence constants, FSM state type, round function
// and parameter legality check. Used by simon_core_param (see SIMON_DECRYPT_EN there).
package simon_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [61:0] SIMON_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] SIMON_Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] SIMON_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] SIMON_Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] SIMON_Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {IDLE, KEXP, RUN} state_t;

  // Rotations operate on the low w bits of a MAX_W container; upper bits must be zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int unsigned s,
                                            input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return ((v << s) | (v >> (w - s))) & mask;
  endfunction

  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] v, input int unsigned s,
                                            input int unsigned w);
    return rotl(v, w - s, w);
  endfunction

  function automatic logic [MAX_W-1:0] simon_f(input logic [MAX_W-1:0] v, input int unsigned w);
    return (rotl(v, 1, w) & rotl(v, 8, w)) ^ rotl(v, 2, w);
  endfunction

  function automatic bit params_ok(input int unsigned w, input int unsigned m, input int unsigned t);
    return (w > 8) && (w <= MAX_W) && (m >= 2) && (m <= 4) && (t > m);
  endfunction

endpackage

// File: rtl/simon_core_param_if.sv
// Host-side start/done handshake and data bus of simon_core_param.
// The decrypt request exists only when SIMON_DECRYPT_EN is defined.
interface simon_core_param_if #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4
);
  logic                          start;
  logic [KEY_WORDS*WORD_W-1:0]   key;
  logic [2*WORD_W-1:0]           plain_text;
  logic [2*WORD_W-1:0]           cipher_text;
  logic                          busy;
  logic                          done;
`ifdef SIMON_DECRYPT_EN
  logic                          decrypt;

  modport master (output start, key, plain_text, decrypt, input cipher_text, busy, done);
  modport slave  (input start, key, plain_text, decrypt, output cipher_text, busy, done);
`else
  modport master (output start, key, plain_text, input cipher_text, busy, done);
  modport slave  (input start, key, plain_text, output cipher_text, busy, done);
`endif
endinterface

// File: rtl/simon_key_sched.sv
// On-the-fly SIMON key schedule: a KEY_WORDS-deep window that steps forward
// (appending k_{i+m}) or in reverse (prepending k_{i-1}).
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter logic [61:0] Z_SEQ     = SIMON_Z0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        step,
  input  logic                        dir,
  input  logic [KEY_WORDS*WORD_W-1:0] key,
  output logic [WORD_W-1:0]           round_key
);

  localparam logic [WORD_W-1:0] C = {{(WORD_W-2){1'b1}}, 2'b00};

  logic [WORD_W-1:0] win [KEY_WORDS];
  logic [5:0]        zc, zc_dec;
  logic [WORD_W-1:0] fwd_tmp, fwd_mix, fwd_new;
  logic [WORD_W-1:0] rev_tmp, rev_mix, rev_new;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned s);
    logic [MAX_W-1:0] r;
    r = rotr(MAX_W'(v), s, WORD_W);
    return r[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] zword(input logic [5:0] idx);
    logic [WORD_W-1:0] zw;
    zw    = '0;
    zw[0] = Z_SEQ[6'd61 - idx];
    return zw;
  endfunction

  // Reverse step solves the forward recurrence for its oldest term, k_{i-1}.
  always_comb begin
    zc_dec  = (zc == 6'd0) ? 6'd61 : zc - 6'd1;
    fwd_tmp = ror(win[KEY_WORDS-1], 3) ^ ((KEY_WORDS == 4) ? win[1] : '0);
    fwd_mix = fwd_tmp ^ ror(fwd_tmp, 1);
    fwd_new = C ^ win[0] ^ fwd_mix ^ zword(zc);
    rev_tmp = ror(win[KEY_WORDS-2], 3) ^ ((KEY_WORDS == 4) ? win[0] : '0);
    rev_mix = rev_tmp ^ ror(rev_tmp, 1);
    rev_new = C ^ win[KEY_WORDS-1] ^ rev_mix ^ zword(zc_dec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < KEY_WORDS; j++) win[j] <= '0;
      zc <= '0;
    end else if (load) begin
      for (int unsigned j = 0; j < KEY_WORDS; j++) win[j] <= key[j*WORD_W +: WORD_W];
      zc <= '0;
    end else if (step) begin
      if (dir) begin
        for (int unsigned j = KEY_WORDS - 1; j > 0; j--) win[j] <= win[j-1];
        win[0] <= rev_new;
        zc     <= zc_dec;
      end else begin
        for (int unsigned j = 0; j < KEY_WORDS - 1; j++) win[j] <= win[j+1];
        win[KEY_WORDS-1] <= fwd_new;
        zc               <= (zc == 6'd61) ? 6'd0 : zc + 6'd1;
      end
    end
  end

  // Reverse stepping keeps the newest valid key at the top of the window.
  assign round_key = dir ? win[KEY_WORDS-1] : win[0];

endmodule

// File: rtl/simon_core_param.sv
// Parametrised SIMON core, one round per clock, on-the-fly key expansion.
// Define SIMON_DECRYPT_EN to add the decrypt request and the KEXP key pre-expansion state.
module simon_core_param
  import simon_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 32,
  parameter logic [61:0] Z_SEQ     = SIMON_Z0
) (
  input  logic               clk,
  input  logic               reset,
  simon_core_param_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   x_q, y_q, x_nxt, y_nxt;
  logic [CNT_W-1:0]    ctr_q;
  logic                dec_q, dec_in;
  logic [2*WORD_W-1:0] ct_q;
  logic                done_q;
  logic [WORD_W-1:0]   round_key;
  logic                run_last, ks_step, ks_dir;

  function automatic logic [WORD_W-1:0] f(input logic [WORD_W-1:0] v);
    logic [MAX_W-1:0] r;
    r = simon_f(MAX_W'(v), WORD_W);
    return r[WORD_W-1:0];
  endfunction

  param_legal: assert property (@(posedge clk) params_ok(WORD_W, KEY_WORDS, ROUNDS));

`ifdef SIMON_DECRYPT_EN
  logic kexp_last;
  assign dec_in    = bus.decrypt;
  assign kexp_last = (state == KEXP) && (ctr_q == CNT_W'(ROUNDS - KEY_WORDS - 1));
`else
  assign dec_in = 1'b0;
`endif

  assign run_last = (state == RUN) && (ctr_q == CNT_W'(ROUNDS - 1));
  assign ks_step  = (state == RUN) || (state == KEXP);
  assign ks_dir   = (state == RUN) && dec_q;

  simon_key_sched #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS),
    .Z_SEQ     (Z_SEQ)
  ) u_key_sched (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == IDLE) && bus.start),
    .step      (ks_step),
    .dir       (ks_dir),
    .key       (bus.key),
    .round_key (round_key)
  );

  always_comb begin
    x_nxt = y_q ^ f(x_q) ^ round_key;
    y_nxt = x_q;
    if (dec_q) begin
      x_nxt = y_q;
      y_nxt = x_q ^ f(y_q) ^ round_key;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = dec_in ? KEXP : RUN;
`ifdef SIMON_DECRYPT_EN
      KEXP: if (kexp_last) state_nxt = RUN;
`endif
      RUN:  if (run_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      ctr_q  <= '0;
      dec_q  <= 1'b0;
      ct_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          x_q   <= bus.plain_text[2*WORD_W-1:WORD_W];
          y_q   <= bus.plain_text[WORD_W-1:0];
          ctr_q <= '0;
          dec_q <= dec_in;
        end
`ifdef SIMON_DECRYPT_EN
        KEXP: ctr_q <= kexp_last ? '0 : ctr_q + 1'b1;
`endif
        RUN: begin
          x_q   <= x_nxt;
          y_q   <= y_nxt;
          ctr_q <= ctr_q + 1'b1;
          if (run_last) begin
            ct_q   <= {x_nxt, y_nxt};
            done_q <= 1'b1;
            ctr_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cipher_text = ct_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state != IDLE);

endmodule
